tl_a_router: RTL and testbench



---
 rtl/tl_a_router.sv | 181 ++++++++++++++++++
 tb/tb_tl_a_router.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_router.sv
// ---------------------------------------------------------------------------
// tl_a_router
//
// Pipeline stage sitting directly in front of the crossbar demux on the
// TileLink A channel. Every accepted beat is registered into a single-entry
// output register. The downstream port index is decoded from the address on
// the first beat of a message and held for every remaining beat of a
// multi-beat message. Messages whose decoded index has no downstream port are
// swallowed (all beats accepted, nothing forwarded) and flagged with a
// one-cycle error pulse.
//
// Optional feature (compile-time macro TL_A_ROUTER_ERRCNT_EN):
//   when defined, adds err_cnt_o, a saturating count of err_o pulses.
//   When undefined, that port and its counter do not exist.
//
// Ports:
//   clk_i     in   clock, all state updates on the rising edge
//   rst_ni    in   asynchronous active-low reset
//   valid_i   in   upstream beat valid
//   ready_o   out  upstream beat accepted when valid_i && ready_o
//   data_i    in   beat payload (opaque)
//   addr_i    in   message address, only looked at on a first beat
//   beats_i   in   beats in the message, only looked at on a first beat;
//                  zero is treated as a single beat
//   valid_o   out  registered beat valid towards the demux
//   ready_i   in   demux ready
//   data_o    out  registered payload
//   sel_o     out  registered port index, constant across a message
//   err_o     out  one-cycle pulse for each unmapped message start
//   err_cnt_o out  [TL_A_ROUTER_ERRCNT_EN only] saturating error count
// ---------------------------------------------------------------------------
module tl_a_router #(
    parameter int N          = 4,
    parameter int SEL_W      = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int REGION_LSB = 28,
    parameter int BEAT_W     = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BEAT_W-1:0] beats_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic              err_o
`ifdef TL_A_ROUTER_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [SEL_W-1:0]   sel_lat;

    logic [SEL_W-1:0]   dec_idx;
    logic [31:0]        dec_idx_ext;
    logic               dec_mapped;
    logic               multi_beat;
    logic               accept;
    logic               fwd_accept;
    logic [SEL_W-1:0]   cur_sel;
    logic               last_beat;
    logic               unused_addr;

    // Only the region field of the address matters; the remaining bits are
    // folded into a dummy net so they are visibly consumed.
    assign unused_addr = ^addr_i;

    // Region decode. The index is widened to 32 bits before comparing with
    // N so that a non-power-of-two port count is handled correctly.
    assign dec_idx     = addr_i[REGION_LSB +: SEL_W];
    assign dec_idx_ext = 32'(dec_idx);
    assign dec_mapped  = dec_idx_ext < 32'(N);

    // A beat count of 0 behaves like 1, so only counts above 1 open a
    // multi-beat message.
    assign multi_beat  = beats_i > BEAT_W'(1);

    // While dropping, beats never touch the output register, so upstream is
    // always ready. Otherwise this is a plain one-entry pipeline register
    // that can drain and reload on the same edge.
    assign ready_o    = (state == DROP) ? 1'b1 : (!valid_o || ready_i);
    assign accept     = valid_i && ready_o;

    // A beat enters the output register when it continues a forwarded
    // message, or when it starts a message that decodes to a real port.
    assign fwd_accept = accept && ((state == FWD) || ((state == IDLE) && dec_mapped));

    // Continuation beats reuse the index latched on the first beat and
    // ignore whatever addr_i carries.
    assign cur_sel    = (state == FWD) ? sel_lat : dec_idx;

    assign last_beat  = beat_cnt == BEAT_W'(1);

    // Message FSM together with the output register. err_o defaults low
    // every cycle so a single assignment gives exactly one cycle of pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            beat_cnt <= '0;
            sel_lat  <= '0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            sel_o    <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= 1'b0;

            if (fwd_accept) begin
                valid_o <= 1'b1;
                data_o  <= data_i;
                sel_o   <= cur_sel;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_mapped) begin
                            if (multi_beat) begin
                                state    <= FWD;
                                beat_cnt <= beats_i - BEAT_W'(1);
                                sel_lat  <= dec_idx;
                            end
                        end else begin
                            err_o <= 1'b1;
                            if (multi_beat) begin
                                state    <= DROP;
                                beat_cnt <= beats_i - BEAT_W'(1);
                            end
                        end
                    end
                end

                FWD, DROP: begin
                    // The counter holds the beats still owed; it only moves
                    // on an accepted beat and stops at the final one.
                    if (accept) begin
                        beat_cnt <= beat_cnt - BEAT_W'(1);
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TL_A_ROUTER_ERRCNT_EN
    // Saturating count of unmapped message starts, driven from the
    // registered pulse so each message counts once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= 16'd0;
        end else if (err_o && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`else
    // Error counter not built; err_o alone reports unmapped messages.
`endif

endmodule

// File: tb/tb_tl_a_router.sv
// ---------------------------------------------------------------------------
// tb_tl_a_router
//
// Self-checking bench for tl_a_router, built with N=3 so that region 3 is an
// unmapped port. Every forwarded beat is pushed into a scoreboard queue when
// it is accepted upstream; a monitor pops and compares on each downstream
// handshake. Scenario tasks run in sequence from one initial block.
// ---------------------------------------------------------------------------
module tb_tl_a_router;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  sel;
    } exp_t;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] data_i;
    logic [31:0] addr_i;
    logic [7:0]  beats_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] data_o;
    logic [1:0]  sel_o;
    logic        err_o;
`ifdef TL_A_ROUTER_ERRCNT_EN
    logic [15:0] err_cnt_o;
`endif

    exp_t sb[$];
    int   checks;
    int   fails;
    int   out_count;
    int   err_cycles;

    tl_a_router #(
        .N(3),
        .SEL_W(2),
        .ADDR_W(32),
        .DATA_W(64),
        .REGION_LSB(28),
        .BEAT_W(8)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i(data_i),
        .addr_i(addr_i),
        .beats_i(beats_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o(data_o),
        .sel_o(sel_o),
        .err_o(err_o)
`ifdef TL_A_ROUTER_ERRCNT_EN
        ,
        .err_cnt_o(err_cnt_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Downstream monitor: a handshake seen on the falling edge completes on
    // the next rising edge, so the beat is compared against the scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (err_o) err_cycles++;
            if (valid_o && ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_output: data=%h sel=%0d, required none", data_o, sel_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (data_o !== e.data || sel_o !== e.sel) begin
                        fails++;
                        $display("[TB] FAIL output_beat: data=%h sel=%0d, required data=%h sel=%0d",
                                 data_o, sel_o, e.data, e.sel);
                    end
                    out_count++;
                end
            end
        end
    end

    // Drives one beat starting just after a rising edge and returns just
    // after the edge on which it was accepted. With rnd set, ready_i starts
    // at a random level and is raised if the register is stalled.
    task automatic send_beat(input logic [31:0] addr, input logic [7:0] beats,
                             input logic [63:0] data, input logic exp_fwd,
                             input logic [1:0] exp_sel, input logic rnd);
        exp_t e;
        logic got;
        got     = 1'b0;
        valid_i = 1'b1;
        addr_i  = addr;
        beats_i = beats;
        data_i  = data;
        if (rnd) ready_i = 1'($urandom_range(0, 1));
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (ready_o) begin
                got = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
            ready_i = 1'b1;
        end
        checks++;
        if (!got) begin
            fails++;
            $display("[TB] FAIL accept_timeout: ready_o=%b, required 1 within 200 cycles", ready_o);
        end
        if (exp_fwd && got) begin
            e.data = data;
            e.sel  = exp_sel;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        ready_i = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) break;
            @(posedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0 || valid_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL drain: pending=%0d valid_o=%b, required 0 and 0", sb.size(), valid_o);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        addr_i  = '0;
        beats_i = '0;
        #12;
        checks++;
        if (valid_o !== 1'b0 || data_o !== 64'd0 || sel_o !== 2'd0 || err_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: valid=%b data=%h sel=%0d err=%b, required all 0",
                     valid_o, data_o, sel_o, err_o);
        end
        checks++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: ready_o=%b, required 1", ready_o);
        end
`ifdef TL_A_ROUTER_ERRCNT_EN
        checks++;
        if (err_cnt_o !== 16'd0) begin
            fails++;
            $display("[TB] FAIL reset_errcnt: err_cnt_o=%0d, required 0", err_cnt_o);
        end
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_single();
        int o, e;
        o = out_count;
        e = err_cycles;
        ready_i = 1'b1;
        send_beat(32'h2000_0000, 8'd1, 64'hDEAD_BEEF_0123_4567, 1'b1, 2'd2, 1'b0);
        checks++;
        if (valid_o !== 1'b1 || sel_o !== 2'd2 || data_o !== 64'hDEAD_BEEF_0123_4567) begin
            fails++;
            $display("[TB] FAIL single_latency: valid=%b sel=%0d data=%h, required 1 2 deadbeef01234567",
                     valid_o, sel_o, data_o);
        end
        wait_drain();
        checks++;
        if (out_count != o + 1 || err_cycles != e) begin
            fails++;
            $display("[TB] FAIL single_counts: outputs=%0d errs=%0d, required %0d %0d",
                     out_count - o, err_cycles - e, 1, 0);
        end
    endtask

    task automatic test_burst();
        int o, e;
        o = out_count;
        e = err_cycles;
        send_beat(32'h1000_0000, 8'd4, 64'h1111_0000_0000_0001, 1'b1, 2'd1, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            send_beat(32'h3000_0000, 8'd9, 64'h1111_0000_0000_0000 + 64'(i), 1'b1, 2'd1, 1'b0);
        end
        // A fresh message right after must decode its own address.
        send_beat(32'h2000_0000, 8'd1, 64'h1111_0000_0000_0005, 1'b1, 2'd2, 1'b0);
        wait_drain();
        checks++;
        if (out_count != o + 5 || err_cycles != e) begin
            fails++;
            $display("[TB] FAIL burst_counts: outputs=%0d errs=%0d, required 5 0",
                     out_count - o, err_cycles - e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        ready_i = 1'b0;
        valid_i = 1'b1;
        addr_i  = 32'h2000_0000;
        beats_i = 8'd1;
        data_i  = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bp_first_ready: ready_o=%b, required 1", ready_o);
        end
        x.data = 64'hAAAA_AAAA_AAAA_AAAA;
        x.sel  = 2'd2;
        sb.push_back(x);
        @(posedge clk_i);
        #1;
        addr_i = 32'h1000_0000;
        data_i = 64'hBBBB_BBBB_BBBB_BBBB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 64'hAAAA_AAAA_AAAA_AAAA || sel_o !== 2'd2) begin
                fails++;
                $display("[TB] FAIL bp_stall: ready=%b valid=%b data=%h sel=%0d, required 0 1 aaaaaaaaaaaaaaaa 2",
                         ready_o, valid_o, data_o, sel_o);
            end
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bp_release_ready: ready_o=%b, required 1", ready_o);
        end
        x.data = 64'hBBBB_BBBB_BBBB_BBBB;
        x.sel  = 2'd1;
        sb.push_back(x);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 64'hBBBB_BBBB_BBBB_BBBB || sel_o !== 2'd1) begin
            fails++;
            $display("[TB] FAIL bp_no_bubble: valid=%b data=%h sel=%0d, required 1 bbbbbbbbbbbbbbbb 1",
                     valid_o, data_o, sel_o);
        end
        @(posedge clk_i);
        #1;
        wait_drain();
    endtask

    task automatic test_unmapped();
        int o, e;
        o = out_count;
        e = err_cycles;
        ready_i = 1'b1;
        valid_i = 1'b1;
        addr_i  = 32'h3000_0000;
        beats_i = 8'd2;
        for (int i = 0; i < 2; i++) begin
            data_i = 64'hCCCC_0000_0000_0000 + 64'(i);
            @(negedge clk_i);
            checks++;
            if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
                fails++;
                $display("[TB] FAIL unmapped_beat: ready=%b valid=%b, required 1 0", ready_o, valid_o);
            end
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        checks++;
        if (out_count != o || err_cycles != e + 1 || valid_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL unmapped_drop: outputs=%0d err_cycles=%0d valid=%b, required 0 1 0",
                     out_count - o, err_cycles - e, valid_o);
        end
`ifdef TL_A_ROUTER_ERRCNT_EN
        checks++;
        if (err_cnt_o !== 16'd1) begin
            fails++;
            $display("[TB] FAIL unmapped_errcnt: err_cnt_o=%0d, required 1", err_cnt_o);
        end
`endif
        // Single-beat unmapped message, then a mapped one to prove IDLE.
        send_beat(32'h3000_0000, 8'd1, 64'hCCCC_0000_0000_0010, 1'b0, 2'd0, 1'b0);
        send_beat(32'h2000_0000, 8'd1, 64'hCCCC_0000_0000_0011, 1'b1, 2'd2, 1'b0);
        wait_drain();
        checks++;
        if (out_count != o + 1 || err_cycles != e + 2) begin
            fails++;
            $display("[TB] FAIL unmapped_single: outputs=%0d err_cycles=%0d, required 1 2",
                     out_count - o, err_cycles - e);
        end
`ifdef TL_A_ROUTER_ERRCNT_EN
        checks++;
        if (err_cnt_o !== 16'd2) begin
            fails++;
            $display("[TB] FAIL unmapped_errcnt2: err_cnt_o=%0d, required 2", err_cnt_o);
        end
`endif
    endtask

    task automatic test_beat_counts();
        int o, e;
        o = out_count;
        e = err_cycles;
        send_beat(32'h1000_0000, 8'd0, 64'hD000_0000_0000_0000, 1'b1, 2'd1, 1'b0);
        send_beat(32'h2000_0000, 8'd1, 64'hD000_0000_0000_0001, 1'b1, 2'd2, 1'b0);
        wait_drain();
        checks++;
        if (out_count != o + 2) begin
            fails++;
            $display("[TB] FAIL beats_zero: outputs=%0d, required 2", out_count - o);
        end
        o = out_count;
        send_beat(32'h0000_0000, 8'd255, 64'hE000_0000_0000_0000, 1'b1, 2'd0, 1'b1);
        for (int i = 1; i < 255; i++) begin
            send_beat(32'h3000_0000, 8'd7, 64'hE000_0000_0000_0000 + 64'(i), 1'b1, 2'd0, 1'b1);
        end
        send_beat(32'h2000_0000, 8'd1, 64'hE000_0000_0000_0FFF, 1'b1, 2'd2, 1'b1);
        wait_drain();
        checks++;
        if (out_count != o + 256 || err_cycles != e) begin
            fails++;
            $display("[TB] FAIL beats_255: outputs=%0d errs=%0d, required 256 0",
                     out_count - o, err_cycles - e);
        end
    endtask

    task automatic test_reset_mid_burst();
        ready_i = 1'b1;
        send_beat(32'h1000_0000, 8'd4, 64'hF000_0000_0000_0001, 1'b1, 2'd1, 1'b0);
        send_beat(32'h0000_0000, 8'd4, 64'hF000_0000_0000_0002, 1'b1, 2'd1, 1'b0);
        rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || sel_o !== 2'd0) begin
            fails++;
            $display("[TB] FAIL async_reset: valid=%b sel=%0d, required 0 0", valid_o, sel_o);
        end
        sb.delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        send_beat(32'h2000_0000, 8'd1, 64'hF000_0000_0000_0003, 1'b1, 2'd2, 1'b0);
        wait_drain();
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        out_count  = 0;
        err_cycles = 0;
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_unmapped();
        test_beat_counts();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
